// File: rtl/gpio_scan_sequencer.sv
// gpio_scan_sequencer: walks a 6-bit GPIO pin index (1..34, 0 = none) from a first to a last pin.
//   clk        system clock, rising edge
//   nrst       asynchronous active-low reset
//   en         run enable; low freezes an active scan
//   start      start request (IDLE only)
//   stop       synchronous abort, overrides en and start
//   loop_mode  wrap from last_pin back to first_pin
//   first_pin  first index of the scan
//   last_pin   last index of the scan
//   dwell      enabled cycles each index is presented
//   pin_idx    index to the one-hot decoder, 0 when idle
//   busy       scan active, including paused
//   done       one-cycle pulse at the end of a non-looping scan
//   cfg_err    one-cycle pulse when a start is rejected
module gpio_scan_sequencer #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               en,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_mode,
   input  logic [5:0]         first_pin,
   input  logic [5:0]         last_pin,
   input  logic [DWELL_W-1:0] dwell,
   output logic [5:0]         pin_idx,
   output logic               busy,
   output logic               done,
   output logic               cfg_err
);
   typedef enum logic {IDLE, SCAN} state_t;
   state_t state, state_n;
   logic [5:0] pin_n, first_q, last_q;
   logic [DWELL_W-1:0] dwell_q, cnt, cnt_n;
   logic loop_q, cfg_ok, done_n, err_n;
   assign cfg_ok = first_pin != 6'd0 && first_pin <= last_pin && last_pin <= 6'd34 && dwell != '0;
   assign busy = state == SCAN;
   always_comb begin
      state_n = state;
      pin_n   = pin_idx;
      cnt_n   = cnt;
      done_n  = 1'b0;
      err_n   = 1'b0;
      if (stop) begin
         state_n = IDLE;
         pin_n   = 6'd0;
         cnt_n   = '0;
      end else if (state == IDLE) begin
         if (start && en) begin
            if (cfg_ok) begin
               state_n = SCAN;
               pin_n   = first_pin;
               cnt_n   = DWELL_W'(1);
            end else begin
               err_n = 1'b1;
            end
         end
      end else if (en) begin
         if (cnt < dwell_q) begin
            cnt_n = cnt + DWELL_W'(1);
         end else begin
            cnt_n = DWELL_W'(1);
            if (pin_idx != last_q) begin
               pin_n = pin_idx + 6'd1;
            end else if (loop_q) begin
               pin_n = first_q;
            end else begin
               state_n = IDLE;
               pin_n   = 6'd0;
               cnt_n   = '0;
               done_n  = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= IDLE;
         pin_idx <= 6'd0;
         cnt     <= '0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         first_q <= 6'd0;
         last_q  <= 6'd0;
         dwell_q <= '0;
         loop_q  <= 1'b0;
      end else begin
         state   <= state_n;
         pin_idx <= pin_n;
         cnt     <= cnt_n;
         done    <= done_n;
         cfg_err <= err_n;
         // config is captured only on an accepted start
         if (state == IDLE && state_n == SCAN) begin
            first_q <= first_pin;
            last_q  <= last_pin;
            dwell_q <= dwell;
            loop_q  <= loop_mode;
         end
      end
   end
endmodule

// File: tb/tb_gpio_scan_sequencer.sv
// tb_gpio_scan_sequencer: directed and randomized checks of gpio_scan_sequencer against a time-based scan model.
module tb_gpio_scan_sequencer;
   logic clk = 1'b0, nrst = 1'b0, en = 1'b0, start = 1'b0, stop = 1'b0, loop_mode = 1'b0;
   logic [5:0] first_pin = 6'd0, last_pin = 6'd0, pin_idx;
   logic [15:0] dwell = 16'd0;
   logic busy, done, cfg_err;
   int n_cmp = 0, n_err = 0;
   bit m_act = 0, m_lp = 0, m_done = 0, m_err = 0;
   int m_f = 0, m_l = 0, m_d = 1, m_t = 0;
   gpio_scan_sequencer #(.DWELL_W(16)) dut (
      .clk(clk), .nrst(nrst), .en(en), .start(start), .stop(stop), .loop_mode(loop_mode),
      .first_pin(first_pin), .last_pin(last_pin), .dwell(dwell),
      .pin_idx(pin_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask
   // Model: pin index derived from enabled cycles elapsed since the accepted start.
   function automatic int m_pin();
      int n = m_l - m_f + 1;
      return m_act ? m_f + (m_t / m_d) % n : 0;
   endfunction
   task automatic check_all(input string tag);
      chk({tag, "_pin"}, int'(pin_idx), m_pin());
      chk({tag, "_busy"}, int'(busy), int'(m_act));
      chk({tag, "_done"}, int'(done), int'(m_done));
      chk({tag, "_err"}, int'(cfg_err), int'(m_err));
   endtask
   task automatic cfg(input int f, input int l, input int d, input bit lp);
      first_pin = 6'(f); last_pin = 6'(l); dwell = 16'(d); loop_mode = lp;
   endtask
   task automatic step(input bit st, input bit e, input bit sp, input string tag);
      start = st; en = e; stop = sp;
      @(posedge clk);
      m_done = 0; m_err = 0;
      if (stop) m_act = 0;
      else if (!m_act) begin
         if (start && en) begin
            if (first_pin >= 1 && first_pin <= last_pin && last_pin <= 34 && dwell != 0) begin
               m_act = 1; m_f = first_pin; m_l = last_pin; m_d = dwell; m_lp = loop_mode; m_t = 0;
            end else m_err = 1;
         end
      end else if (en) begin
         m_t++;
         if (m_t == (m_l - m_f + 1) * m_d) begin
            if (m_lp) m_t = 0;
            else begin m_act = 0; m_done = 1; end
         end
      end
      #1;
      check_all(tag);
   endtask
   initial begin
      int cnt;
      #1;
      check_all("reset");
      #3 nrst = 1'b1;
      // full-bank walking one, dwell 1
      cfg(1, 34, 1, 0);
      step(1, 1, 0, "t1_start");
      cnt = int'(busy);
      for (int i = 0; i < 40; i++) begin
         step(0, 1, 0, "t1");
         cnt += int'(busy);
      end
      chk("t1_busy_cycles", cnt, 34);
      // looping scan then stop
      cfg(5, 7, 3, 1);
      step(1, 1, 0, "t2_start");
      for (int i = 0; i < 25; i++) step(0, 1, 0, "t2");
      step(0, 1, 1, "t2_stop");
      step(0, 1, 0, "t2_after");
      // rejected configs
      cfg(0, 5, 2, 0);   step(1, 1, 0, "t3_first0");  step(0, 1, 0, "t3_idle");
      cfg(1, 35, 2, 0);  step(1, 1, 0, "t3_last35");  step(0, 1, 0, "t3_idle");
      cfg(10, 9, 2, 0);  step(1, 1, 0, "t3_order");   step(0, 1, 0, "t3_idle");
      cfg(3, 4, 0, 0);   step(1, 1, 0, "t3_dwell0");  step(0, 1, 0, "t3_idle");
      // ignored starts in IDLE
      cfg(2, 3, 1, 0);   step(1, 0, 0, "t3_en0");     step(1, 1, 1, "t3_stop");
      // single pin with a pause mid-dwell
      cfg(34, 34, 4, 0);
      step(1, 1, 0, "t4_start");
      cnt = int'(pin_idx == 6'd34);
      step(0, 1, 0, "t4"); cnt += int'(pin_idx == 6'd34);
      step(0, 0, 0, "t4_pause"); cnt += int'(pin_idx == 6'd34);
      step(0, 0, 0, "t4_pause"); cnt += int'(pin_idx == 6'd34);
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 0, "t4"); cnt += int'(pin_idx == 6'd34);
      end
      chk("t4_pin34_cycles", cnt, 6);
      // start while busy, then back-to-back start on the done cycle
      cfg(3, 4, 2, 0);
      step(1, 1, 0, "t5_start");
      cfg(20, 30, 5, 1);
      step(1, 1, 0, "t5_busy_start");
      cnt = 0;
      while (!m_done && cnt < 20) begin step(0, 1, 0, "t5"); cnt++; end
      chk("t5_done_seen", int'(m_done), 1);
      cfg(8, 9, 1, 0);
      step(1, 1, 0, "t5_b2b");
      for (int i = 0; i < 4; i++) step(0, 1, 0, "t5_b2b_run");
      // async reset at pin 12
      cfg(10, 20, 2, 0);
      step(1, 1, 0, "t6_start");
      cnt = 0;
      while (m_pin() != 12 && cnt < 20) begin step(0, 1, 0, "t6"); cnt++; end
      chk("t6_reached12", int'(pin_idx), 12);
      #2 nrst = 1'b0;
      #1;
      m_act = 0; m_done = 0; m_err = 0;
      check_all("t6_async");
      @(posedge clk); #1;
      check_all("t6_held");
      nrst = 1'b1;
      for (int i = 0; i < 5; i++) step(0, 1, 0, "t6_after");
      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 4) != 0) begin
            int f = $urandom_range(1, 34);
            cfg(f, $urandom_range(f, f + 5 > 34 ? 34 : f + 5), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
         end else cfg($urandom_range(0, 36), $urandom_range(0, 36), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         step($urandom_range(0, 4) == 0, $urandom_range(0, 6) != 0, $urandom_range(0, 40) == 0, "rnd");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/gpio_scan_sequencer.md
# gpio_scan_sequencer

Programmable pin-scan sequencer sitting directly upstream of the GPIO one-hot decoder. It generates the 6-bit pin index (1..34, 0 = no pin) that the decoder turns into the 34-bit GPIO select. A scan is a walk from a first pin to a last pin, presenting each index for a programmable dwell time, optionally looping. Used to drive walking-one patterns and timed per-pin strobes across the GPIO bank.

## Interface
Parameters:
- DWELL_W, 16, width of the dwell-time field and internal dwell counter

Ports:
- clk  in  1  system clock, all state updates on rising edge
- nrst  in  1  asynchronous active-low reset
- en  in  1  run enable; low pauses an active scan (state, index and counters frozen)
- start  in  1  start request, sampled each cycle
- stop  in  1  synchronous abort
- loop_mode  in  1  1 = wrap from last_pin back to first_pin indefinitely
- first_pin  in  6  first index of scan
- last_pin  in  6  last index of scan
- dwell  in  DWELL_W  cycles each index is presented
- pin_idx  out  6  index to decoder input; 0 whenever not scanning
- busy  out  1  high while scan active (including paused)
- done  out  1  one-cycle pulse at normal end of a non-looping scan
- cfg_err  out  1  one-cycle pulse when start is rejected for bad config

## Operation
- Reset (nrst low, async): state IDLE, pin_idx=0, busy=0, done=0, cfg_err=0, internal counters 0.
- States: IDLE, SCAN.
- IDLE: start=1 with en=1 and stop=0 is a start request. Config valid iff 1 <= first_pin <= last_pin <= 34 and dwell != 0.
  - Valid: latch first_pin, last_pin, dwell, loop_mode; pin_idx <= first_pin; dwell counter <= 1; go to SCAN; busy <= 1.
  - Invalid: cfg_err pulses one cycle, stay IDLE, pin_idx stays 0.
  - start with en=0 or stop=1 ignored, no cfg_err.
- SCAN, per cycle with en=1, stop=0:
  - dwell counter < latched dwell: counter increments, pin_idx held.
  - counter == dwell and pin_idx < last: pin_idx increments by 1, counter <= 1.
  - counter == dwell and pin_idx == last, loop: pin_idx <= first, counter <= 1.
  - counter == dwell and pin_idx == last, no loop: go IDLE, pin_idx <= 0, busy <= 0, done <= 1 (single cycle).
- SCAN with en=0: everything frozen; busy stays 1.
- stop=1 in any state: next cycle IDLE, pin_idx=0, busy=0, no done, no cfg_err. stop overrides en and start.
- start during SCAN ignored; inputs first_pin/last_pin/dwell/loop_mode only sampled on accepted start.
- Never emits pin_idx outside 0..34.

## Timing
- Accepted start at edge k: pin_idx=first_pin, busy=1 from edge k onward.
- Each index visible exactly dwell enabled cycles; en-low cycles extend the hold by the same count.
- Non-looping scan of N = last-first+1 pins completes N*dwell enabled cycles after start edge; done and pin_idx=0, busy=0 all appear on the same edge.
- done and cfg_err are registered, high exactly one cycle.
- first_pin == last_pin: single-pin scan, dwell cycles then done.
- dwell=1: index changes every enabled cycle.
- Reset asserted mid-scan: outputs go to reset values immediately, asynchronously; no done.
- Back-to-back: start in the cycle done is high is accepted (state already IDLE).

## Test plan
- Reset, then start with first=1, last=34, dwell=1, loop=0 -> pin_idx steps 1..34 on successive cycles, then 0 with done=1 for one cycle; busy high for exactly 34 cycles.
- first=5, last=7, dwell=3, loop=1 -> pin_idx 5,5,5,6,6,6,7,7,7,5,... ; done never asserted; stop -> pin_idx=0, busy=0 next cycle, no done.
- Invalid starts: first=0; last=35; first=10,last=9; dwell=0 -> each gives one-cycle cfg_err, pin_idx stays 0, busy stays 0.
- first=last=34, dwell=4, en dropped for 2 cycles mid-dwell -> pin_idx=34 for 6 cycles total, then done.
- Start asserted while busy and start with en=0 in IDLE -> ignored, scan timing unchanged; start on done cycle -> new scan begins next edge.
- nrst pulled low mid-scan at pin 12 -> pin_idx=0, busy=0 immediately; after release, no done and stays IDLE.
